// File: rtl/instr_fetch_unit.sv
// Instruction fetch / PC update stage feeding the multicycle control FSM.
// Optional: define FETCH_MISALIGN_TRAP_EN to suppress misaligned PC writes and flag them.
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Load_ir,
    input  logic        pcWrite,
    input  logic        PCWriteCond,
    input  logic        pcWriteCondBne,
    input  logic        pcWriteCondBge,
    input  logic        pcWriteCondBlt,
    input  logic        pcSource,
    input  logic [63:0] AluResult,
    input  logic [63:0] AluOut,
    input  logic        zero,
    input  logic        lt,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    output logic [31:0] Instruction,
    output logic [63:0] pc,
    output logic        fetch_busy,
    output logic        fetch_err,
    output logic        misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam logic [7:0]  LAST_WAIT = 8'(TIMEOUT - 1);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    state_t      state;
    logic [7:0]  waitCnt;
    logic        pcWe;
    logic [63:0] pcTarget;

    always_comb begin
        pcWe = pcWrite
             | (PCWriteCond    &  zero)
             | (pcWriteCondBne & ~zero)
             | (pcWriteCondBge & ~lt)
             | (pcWriteCondBlt &  lt);
        pcTarget = pcSource ? AluOut : AluResult;
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            misaligned <= 1'b0;
        end else if (pcWe) begin
            if (pcTarget[1:0] == 2'b00) begin
                pc <= pcTarget;
            end else begin
                misaligned <= 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (pcWe) begin
            pc <= {pcTarget[63:2], 2'b00};
        end
    end

    assign misaligned = 1'b0;
`endif

    // imem_addr doubles as the latched fetch address, so PC writes mid-fetch cannot disturb it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            Instruction <= '0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            fetch_busy  <= 1'b0;
            fetch_err   <= 1'b0;
            waitCnt     <= '0;
        end else begin
            fetch_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (Load_ir) begin
                        imem_addr  <= pc;
                        imem_req   <= 1'b1;
                        fetch_busy <= 1'b1;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    imem_req <= 1'b0;
                    if (imem_valid) begin
                        Instruction <= imem_rdata;
                        fetch_busy  <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        waitCnt <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_valid) begin
                        Instruction <= imem_rdata;
                        fetch_busy  <= 1'b0;
                        state       <= IDLE;
                    end else if (waitCnt == LAST_WAIT) begin
                        Instruction <= NOP_INSTR;
                        fetch_err   <= 1'b1;
                        fetch_busy  <= 1'b0;
                        waitCnt     <= '0;
                        state       <= IDLE;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                default: begin
                    imem_req   <= 1'b0;
                    fetch_busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (RESET_PC = 0x100, TIMEOUT = 15).
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Load_ir, pcWrite, PCWriteCond, pcWriteCondBne, pcWriteCondBge, pcWriteCondBlt;
    logic        pcSource, zero, lt, imem_valid;
    logic [63:0] AluResult, AluOut;
    logic [31:0] imem_rdata;
    logic        imem_req, fetch_busy, fetch_err, misaligned;
    logic [63:0] imem_addr, pc;
    logic [31:0] Instruction;

    int errCount   = 0;
    int checkCount = 0;

    instr_fetch_unit #(.RESET_PC(64'h100), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .Load_ir(Load_ir), .pcWrite(pcWrite),
        .PCWriteCond(PCWriteCond), .pcWriteCondBne(pcWriteCondBne),
        .pcWriteCondBge(pcWriteCondBge), .pcWriteCondBlt(pcWriteCondBlt),
        .pcSource(pcSource), .AluResult(AluResult), .AluOut(AluOut),
        .zero(zero), .lt(lt), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .imem_req(imem_req), .imem_addr(imem_addr), .Instruction(Instruction),
        .pc(pc), .fetch_busy(fetch_busy), .fetch_err(fetch_err), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearStrobes();
        Load_ir = 0; pcWrite = 0; PCWriteCond = 0; pcWriteCondBne = 0;
        pcWriteCondBge = 0; pcWriteCondBlt = 0; pcSource = 0;
    endtask

    initial begin
        int busyCycles;
        logic errSeen;
        reset = 1; clearStrobes();
        zero = 0; lt = 0; AluResult = '0; AluOut = '0;
        imem_rdata = '0; imem_valid = 0;
        tick(); tick();

        chk("rst_pc", pc, 64'h100);
        chk("rst_instr", Instruction, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_busy", fetch_busy, 0);
        chk("rst_err", fetch_err, 0);
        chk("rst_mis", misaligned, 0);
        reset = 0;
        tick();

        // zero-wait fetch
        Load_ir = 1;
        tick();
        Load_ir = 0;
        chk("zw_req", imem_req, 1);
        chk("zw_addr", imem_addr, 64'h100);
        chk("zw_busy", fetch_busy, 1);
        imem_valid = 1; imem_rdata = 32'h00A00093;
        tick();
        imem_valid = 0;
        chk("zw_instr", Instruction, 32'h00A00093);
        chk("zw_busy_done", fetch_busy, 0);
        chk("zw_req_done", imem_req, 0);

        // latency-3 fetch with same-cycle PC write
        Load_ir = 1; pcWrite = 1; AluResult = 64'h104;
        tick();
        clearStrobes();
        chk("l3_addr", imem_addr, 64'h100);
        chk("l3_pc", pc, 64'h104);
        busyCycles = fetch_busy ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) chk("l3_req_wait", imem_req, 0);
            if (fetch_busy) busyCycles++;
        end
        imem_valid = 1; imem_rdata = 32'h12345678;
        tick();
        imem_valid = 0;
        chk("l3_busy_cycles", busyCycles, 4);
        chk("l3_busy_done", fetch_busy, 0);
        chk("l3_instr", Instruction, 32'h12345678);
        chk("l3_addr_hold", imem_addr, 64'h100);

        // conditional writes
        PCWriteCond = 1; zero = 0; AluResult = 64'h300;
        tick();
        clearStrobes();
        chk("beq_nt", pc, 64'h104);
        pcWriteCondBge = 1; lt = 1;
        tick();
        clearStrobes();
        chk("bge_nt", pc, 64'h104);
        pcWriteCondBlt = 1; lt = 1; pcSource = 1; AluOut = 64'h200;
        tick();
        clearStrobes();
        lt = 0;
        chk("blt_t", pc, 64'h200);

        // timeout: no valid for 15 WAIT cycles
        Load_ir = 1;
        tick();
        Load_ir = 0;
        errSeen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (fetch_err) errSeen = 1;
        end
        chk("to_early_err", errSeen, 0);
        chk("to_busy_before", fetch_busy, 1);
        tick();
        chk("to_err", fetch_err, 1);
        chk("to_nop", Instruction, 32'h00000013);
        chk("to_busy", fetch_busy, 0);
        imem_valid = 1; imem_rdata = 32'hDEADBEEF;
        tick();
        imem_valid = 0;
        chk("to_err_pulse", fetch_err, 0);
        chk("stray_valid", Instruction, 32'h00000013);

        // misaligned PC target
        pcWrite = 1; AluResult = 64'h102;
        tick();
        clearStrobes();
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_pc", pc, 64'h200);
        chk("mis_flag", misaligned, 1);
`else
        chk("mis_pc", pc, 64'h100);
        chk("mis_flag", misaligned, 0);
`endif

        // reset in the middle of WAIT
        Load_ir = 1;
        tick();
        Load_ir = 0;
        tick();
        chk("rw_busy_pre", fetch_busy, 1);
        #2 reset = 1;
        #1;
        chk("rw_req", imem_req, 0);
        chk("rw_busy", fetch_busy, 0);
        chk("rw_pc", pc, 64'h100);
        #2 reset = 0;
        imem_valid = 1; imem_rdata = 32'hCAFEF00D;
        tick();
        imem_valid = 0;
        chk("rw_instr", Instruction, 0);
        chk("rw_busy_post", fetch_busy, 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
